program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader_pkg.sv | 20 ++
 rtl/program_loader_instr_ram.sv | 29 ++
 rtl/program_loader.sv | 82 ++++++++
 tb/tb_program_loader.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// Shared constants, FSM encoding and the default boot program for the
// processor blocks.
package program_loader_pkg;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [DATA_W-1:0] DEFAULT_IMAGE [DEPTH] = '{
    8'hAB, 8'hDE, 8'h3C, 8'hD6, 8'hBC, 8'hCD, 8'hAE, 8'hA1,
    8'hB2, 8'hD4, 8'hE5, 8'hF6, 8'hAF, 8'hEF, 8'h67, 8'h88
  };

endpackage

// File: rtl/program_loader_instr_ram.sv
// 16x8 instruction store: one synchronous write port, one combinational read
// port, contents restored to the default program on reset.
module instr_ram
  import program_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= DEFAULT_IMAGE[i];
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/program_loader.sv
// Program loader: streams a 16-byte program into instruction RAM while
// holding the processor in reset, and keeps a running mod-256 checksum.
module program_loader
  import program_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              load_abort,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_instr,
  output logic              cpu_hold,
  output logic              load_done,
  output logic [DATA_W-1:0] checksum
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic              xfer;
  logic              last_word;

  // An abort in the same cycle as an offered byte wins: the byte is dropped.
  assign xfer      = (state == ST_LOAD) && wr_valid && !load_abort;
  assign last_word = (cnt == ADDR_W'(DEPTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:  if (load_start) state_nxt = ST_LOAD;
      ST_LOAD: begin
        if (load_abort) begin
          state_nxt = ST_RUN;
        end else if (xfer && last_word) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_RUN;
      default: state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    wr_ready  = (state == ST_LOAD);
    cpu_hold  = (state != ST_RUN);
    load_done = (state == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      checksum <= '0;
    end else if (state == ST_RUN && load_start) begin
      cnt      <= '0;
      checksum <= '0;
    end else if (xfer) begin
      cnt      <= cnt + 1'b1;
      checksum <= checksum + wr_data;
    end
  end

  instr_ram u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (xfer),
    .waddr (cnt),
    .wdata (wr_data),
    .raddr (rd_addr),
    .rdata (rd_instr)
  );

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: default-image table, full loads,
// stalled load, abort, mid-load reset and held load_start.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_start, load_abort, wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic [3:0] rd_addr;
  logic [7:0] rd_instr;
  logic       cpu_hold, load_done;
  logic [7:0] checksum;

  program_loader dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .load_abort (load_abort),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .rd_addr    (rd_addr),
    .rd_instr   (rd_instr),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  typedef struct { logic [3:0] addr; logic [7:0] data; } rec_t;

  rec_t       vecs [16];
  rec_t       sb [$];
  logic [7:0] dflt [16] = '{8'hAB, 8'hDE, 8'h3C, 8'hD6, 8'hBC, 8'hCD, 8'hAE, 8'hA1,
                            8'hB2, 8'hD4, 8'hE5, 8'hF6, 8'hAF, 8'hEF, 8'h67, 8'h88};
  int         errors = 0;
  int         checks = 0;
  int         done_pulses = 0;
  logic [7:0] sum_model;
  logic [3:0] waddr;

  always @(posedge clk) if (load_done) done_pulses++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic v);
    wr_valid = v;
    wr_data  = d;
    if (v) begin
      sb.push_back('{waddr, d});
      sum_model = sum_model + d;
      waddr     = waddr + 1'b1;
    end
    tick();
  endtask

  task automatic drain();
    rec_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      rd_addr = e.addr;
      #1;
      check("mem_word", rd_instr, e.data);
    end
  endtask

  task automatic check_default_table();
    for (int i = 0; i < 16; i++) begin
      rd_addr = vecs[i].addr;
      #1;
      check("default_image", rd_instr, vecs[i].data);
    end
  endtask

  task automatic start_load();
    load_start = 1'b1;
    sum_model  = 8'h00;
    waddr      = 4'd0;
    tick();
    load_start = 1'b0;
    check("in_load_ready", wr_ready, 1'b1);
    check("in_load_hold", cpu_hold, 1'b1);
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    #1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int pulses0;
    int load_cycles;

    for (int i = 0; i < 16; i++) vecs[i] = '{4'(i), dflt[i]};

    rst = 1'b1; load_start = 0; load_abort = 0; wr_valid = 0; wr_data = 0; rd_addr = 0;
    #2;
    check("rst_cpu_hold", cpu_hold, 1'b0);
    check("rst_wr_ready", wr_ready, 1'b0);
    check("rst_load_done", load_done, 1'b0);
    check("rst_checksum", checksum, 8'h00);
    tick(); tick();
    rst = 1'b0;
    tick();
    check("run_cpu_hold", cpu_hold, 1'b0);
    check("run_wr_ready", wr_ready, 1'b0);
    check_default_table();

    // 16 back-to-back bytes 0x00..0x0F
    pulses0 = done_pulses;
    start_load();
    rd_addr = 4'd0;
    wr_valid = 1'b1; wr_data = 8'h00;
    #1;
    check("pre_write_visible", rd_instr, 8'hAB);
    for (int i = 0; i < 16; i++) send(8'(i), 1'b1);
    wr_valid = 1'b0;
    check("done_pulse", load_done, 1'b1);
    check("done_hold", cpu_hold, 1'b1);
    check("done_ready", wr_ready, 1'b0);
    check("seq_checksum", checksum, 8'h78);
    check("seq_checksum_model", checksum, sum_model);
    tick();
    check("after_done_hold", cpu_hold, 1'b0);
    check("after_done_pulse", load_done, 1'b0);
    tick();
    check("done_pulse_count", done_pulses - pulses0, 1);
    drain();

    // 0xFF with wr_valid toggling: stalls must not change anything
    pulses0 = done_pulses;
    start_load();
    load_cycles = 0;
    for (int c = 0; c < 32; c++) begin
      if (wr_ready) load_cycles++;
      send(8'hFF, c[0]);
    end
    wr_valid = 1'b0;
    check("toggle_load_cycles", load_cycles, 32);
    check("toggle_done", load_done, 1'b1);
    check("toggle_checksum", checksum, 8'hF0);
    check("toggle_writes", sb.size(), 16);
    tick();
    check("toggle_run", cpu_hold, 1'b0);
    check("toggle_pulses", done_pulses - pulses0, 1);
    drain();

    // abort together with the 5th byte
    reset_pulse();
    pulses0 = done_pulses;
    start_load();
    for (int i = 0; i < 4; i++) send(8'h11 + 8'(i), 1'b1);
    wr_valid = 1'b1; wr_data = 8'h99; load_abort = 1'b1;
    tick();
    wr_valid = 1'b0; load_abort = 1'b0;
    check("abort_hold", cpu_hold, 1'b0);
    check("abort_ready", wr_ready, 1'b0);
    check("abort_done", load_done, 1'b0);
    check("abort_checksum", checksum, sum_model);
    drain();
    rd_addr = 4'd4; #1;
    check("abort_mem4", rd_instr, 8'hBC);
    rd_addr = 4'd5; #1;
    check("abort_mem5", rd_instr, 8'hCD);
    load_abort = 1'b1;
    tick();
    load_abort = 1'b0;
    check("abort_in_run_ignored", cpu_hold, 1'b0);
    check("abort_no_pulse", done_pulses - pulses0, 0);

    // asynchronous reset after 8 accepted bytes
    start_load();
    for (int i = 0; i < 8; i++) send(8'h50 + 8'(i), 1'b1);
    sb.delete();
    rst = 1'b1;
    #1;
    check("midrst_hold", cpu_hold, 1'b0);
    check("midrst_ready", wr_ready, 1'b0);
    check("midrst_checksum", checksum, 8'h00);
    check("midrst_done", load_done, 1'b0);
    tick();
    rst = 1'b0;
    check_default_table();

    // load_start held high through LOAD and DONE
    pulses0 = done_pulses;
    load_start = 1'b1;
    sum_model = 8'h00; waddr = 4'd0;
    tick();
    check("held_enter_load", wr_ready, 1'b1);
    for (int i = 0; i < 16; i++) begin
      send(8'hA0 + 8'(i), 1'b1);
      if (i == 7) check("held_no_restart", checksum, sum_model);
    end
    wr_valid = 1'b0;
    check("held_done", load_done, 1'b1);
    check("held_checksum", checksum, sum_model);
    tick();
    check("held_run_after_done", cpu_hold, 1'b0);
    tick();
    check("held_reload", wr_ready, 1'b1);
    check("held_reload_checksum", checksum, 8'h00);
    load_start = 1'b0; load_abort = 1'b1;
    tick();
    load_abort = 1'b0;
    check("held_abort_run", cpu_hold, 1'b0);
    check("held_pulses", done_pulses - pulses0, 1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
